// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between instruction fetch (IF)
// and data memory (DM); a tag pipeline steers read data back to its owner READ_LATENCY cycles later.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                dm_req_valid,
  input  logic                dm_req_write,
  input  logic [ADDR_W-1:0]   dm_req_addr,
  input  logic [DATA_W-1:0]   dm_req_wdata,
  input  logic [DATA_W/8-1:0] dm_req_be,
  output logic                dm_req_ready,
  output logic                dm_rsp_valid,
  output logic [DATA_W-1:0]   dm_rsp_data,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_clken,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata
);

  // state     | meaning
  // GRANT_IF  | IF won the last accepted transfer; DM wins the next tie
  // GRANT_DM  | DM won the last accepted transfer (reset value); IF wins the next tie
  typedef enum logic {GRANT_IF, GRANT_DM} grant_t;

  grant_t                  last_grant, last_grant_nxt;
  logic                    grant_if, grant_dm, issue_read;
  logic [READ_LATENCY-1:0] tag_vld, tag_dm;
  logic                    rsp_vld, rsp_dm;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= GRANT_DM;
      tag_vld    <= '0;
      tag_dm     <= '0;
    end else begin
      last_grant <= last_grant_nxt;
      tag_vld[0] <= issue_read;
      tag_dm[0]  <= grant_dm;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_dm[i]  <= tag_dm[i-1];
      end
    end
  end

  // Grants are forced low in reset so the readies and memory drive stay quiet.
  always_comb begin
    grant_if       = 1'b0;
    grant_dm       = 1'b0;
    last_grant_nxt = last_grant;
    if (reset_n) begin
      if (if_req_valid && dm_req_valid) begin
        grant_if = (last_grant == GRANT_DM);
        grant_dm = (last_grant == GRANT_IF);
      end else begin
        grant_if = if_req_valid;
        grant_dm = dm_req_valid;
      end
    end
    if (grant_if)      last_grant_nxt = GRANT_IF;
    else if (grant_dm) last_grant_nxt = GRANT_DM;
    issue_read = grant_if || (grant_dm && !dm_req_write);
  end

  assign if_req_ready = grant_if;
  assign dm_req_ready = grant_dm;

  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    mem_byteenable = '0;
    if (grant_if) begin
      mem_chipselect = 1'b1;
      mem_address    = if_req_addr;
      mem_byteenable = '1;
    end else if (grant_dm) begin
      mem_chipselect = 1'b1;
      mem_address    = dm_req_addr;
      if (dm_req_write) begin
        mem_write      = 1'b1;
        mem_writedata  = dm_req_wdata;
        mem_byteenable = dm_req_be;
      end else begin
        mem_byteenable = '1;
      end
    end
  end

  assign mem_clken = reset_n;

  assign rsp_vld      = tag_vld[READ_LATENCY-1];
  assign rsp_dm       = tag_dm[READ_LATENCY-1];
  assign if_rsp_valid = rsp_vld && !rsp_dm;
  assign dm_rsp_valid = rsp_vld && rsp_dm;
  assign if_rsp_data  = if_rsp_valid ? mem_readdata : '0;
  assign dm_rsp_data  = dm_rsp_valid ? mem_readdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives two arbiter instances (read latency 1 and 3) from shared stimulus
// and compares them against a transaction-level model of grant, memory drive and read returns.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_v, dm_v, dm_wr;
  logic [15:0] if_addr, dm_addr, dm_wd;
  logic [1:0]  dm_be;

  logic        a_if_rdy, a_if_rv, a_dm_rdy, a_dm_rv, a_clken, a_cs, a_wr;
  logic [15:0] a_if_rd, a_dm_rd, a_addr, a_wd, a_rd;
  logic [1:0]  a_be;
  logic        b_if_rdy, b_if_rv, b_dm_rdy, b_dm_rv, b_clken, b_cs, b_wr;
  logic [15:0] b_if_rd, b_dm_rd, b_addr, b_wd, b_rd;
  logic [1:0]  b_be;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .if_req_valid(if_v), .if_req_addr(if_addr), .if_req_ready(a_if_rdy),
    .if_rsp_valid(a_if_rv), .if_rsp_data(a_if_rd),
    .dm_req_valid(dm_v), .dm_req_write(dm_wr), .dm_req_addr(dm_addr),
    .dm_req_wdata(dm_wd), .dm_req_be(dm_be), .dm_req_ready(a_dm_rdy),
    .dm_rsp_valid(a_dm_rv), .dm_rsp_data(a_dm_rd),
    .mem_address(a_addr), .mem_clken(a_clken), .mem_chipselect(a_cs), .mem_write(a_wr),
    .mem_writedata(a_wd), .mem_byteenable(a_be), .mem_readdata(a_rd));

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LATENCY(3)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .if_req_valid(if_v), .if_req_addr(if_addr), .if_req_ready(b_if_rdy),
    .if_rsp_valid(b_if_rv), .if_rsp_data(b_if_rd),
    .dm_req_valid(dm_v), .dm_req_write(dm_wr), .dm_req_addr(dm_addr),
    .dm_req_wdata(dm_wd), .dm_req_be(dm_be), .dm_req_ready(b_dm_rdy),
    .dm_rsp_valid(b_dm_rv), .dm_rsp_data(b_dm_rd),
    .mem_address(b_addr), .mem_clken(b_clken), .mem_chipselect(b_cs), .mem_write(b_wr),
    .mem_writedata(b_wd), .mem_byteenable(b_be), .mem_readdata(b_rd));

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] be);
    return {be[1] ? nw[15:8] : old[15:8], be[0] ? nw[7:0] : old[7:0]};
  endfunction

  // Memory system models: one per instance, registered read of 1 and 3 cycles.
  logic [15:0] mem_a [logic [15:0]];
  logic [15:0] mem_b [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] b_p0, b_p1;

  initial begin
    logic [15:0] d;
    a_rd = 16'h0;
    forever begin
      @(posedge clk);
      if (a_cs) begin
        d = mem_a.exists(a_addr) ? mem_a[a_addr] : init_val(a_addr);
        if (a_wr) mem_a[a_addr] = merge(d, a_wd, a_be);
        else      a_rd = d;
      end
    end
  end

  initial begin
    logic [15:0] d;
    b_rd = 16'h0; b_p0 = 16'h0; b_p1 = 16'h0;
    forever begin
      @(posedge clk);
      b_rd = b_p1;
      b_p1 = b_p0;
      b_p0 = 16'hDEAD;
      if (b_cs) begin
        d = b_addr;
        d = mem_b.exists(b_addr) ? mem_b[b_addr] : init_val(b_addr);
        if (b_wr) mem_b[b_addr] = merge(d, b_wd, b_be);
        else      b_p0 = d;
      end
    end
  end

  typedef struct {
    int          due;
    bit          dm;
    logic [15:0] data;
  } rsp_t;

  rsp_t qa[$];
  rsp_t qb[$];
  int   cyc, n_vec, n_err;
  bit   last_dm;
  int   last_win;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One cycle: check the settled outputs against the model, advance the model, step the clock.
  task automatic tick();
    int          win;
    logic        e_cs, e_wr;
    logic [15:0] e_addr, e_wd, d;
    logic [1:0]  e_be;
    logic        ea_iv, ea_dv, eb_iv, eb_dv;
    logic [15:0] ea_d, eb_d;
    #1;
    win = 0;
    if (!reset_n) begin
      qa.delete(); qb.delete(); last_dm = 1'b1;
    end else if (if_v && dm_v) win = last_dm ? 1 : 2;
    else if (if_v) win = 1;
    else if (dm_v) win = 2;

    e_cs = (win != 0); e_wr = 1'b0; e_addr = 16'h0; e_wd = 16'h0; e_be = 2'b00;
    if (win == 1) begin e_addr = if_addr; e_be = 2'b11; end
    if (win == 2) begin
      e_addr = dm_addr;
      if (dm_wr) begin e_wr = 1'b1; e_wd = dm_wd; e_be = dm_be; end
      else e_be = 2'b11;
    end

    chk("a_if_ready", a_if_rdy, win == 1);  chk("a_dm_ready", a_dm_rdy, win == 2);
    chk("b_if_ready", b_if_rdy, win == 1);  chk("b_dm_ready", b_dm_rdy, win == 2);
    chk("a_mem_cs", a_cs, e_cs);            chk("b_mem_cs", b_cs, e_cs);
    chk("a_mem_wr", a_wr, e_wr);            chk("b_mem_wr", b_wr, e_wr);
    chk("a_mem_addr", a_addr, e_addr);      chk("b_mem_addr", b_addr, e_addr);
    chk("a_mem_wdata", a_wd, e_wd);         chk("b_mem_wdata", b_wd, e_wd);
    chk("a_mem_be", a_be, e_be);            chk("b_mem_be", b_be, e_be);
    chk("a_clken", a_clken, reset_n);       chk("b_clken", b_clken, reset_n);

    ea_iv = 0; ea_dv = 0; ea_d = 0; eb_iv = 0; eb_dv = 0; eb_d = 0;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      ea_iv = !qa[0].dm; ea_dv = qa[0].dm; ea_d = qa[0].data; void'(qa.pop_front());
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      eb_iv = !qb[0].dm; eb_dv = qb[0].dm; eb_d = qb[0].data; void'(qb.pop_front());
    end
    chk("a_if_rsp_valid", a_if_rv, ea_iv);  chk("a_dm_rsp_valid", a_dm_rv, ea_dv);
    chk("a_if_rsp_data", a_if_rd, ea_iv ? ea_d : 16'h0);
    chk("a_dm_rsp_data", a_dm_rd, ea_dv ? ea_d : 16'h0);
    chk("b_if_rsp_valid", b_if_rv, eb_iv);  chk("b_dm_rsp_valid", b_dm_rv, eb_dv);
    chk("b_if_rsp_data", b_if_rd, eb_iv ? eb_d : 16'h0);
    chk("b_dm_rsp_data", b_dm_rd, eb_dv ? eb_d : 16'h0);

    if (win != 0) begin
      last_dm = (win == 2);
      d = ref_mem.exists(e_addr) ? ref_mem[e_addr] : init_val(e_addr);
      if (e_wr) ref_mem[e_addr] = merge(d, dm_wd, dm_be);
      else begin
        qa.push_back('{cyc + 1, win == 2, d});
        qb.push_back('{cyc + 3, win == 2, d});
      end
    end
    last_win = win;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle();
    if_v = 0; dm_v = 0; dm_wr = 0; if_addr = 0; dm_addr = 0; dm_wd = 0; dm_be = 0;
  endtask

  task automatic dm_req(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                        input logic [1:0] be);
    dm_v = 1; dm_wr = wr; dm_addr = a; dm_wd = wd; dm_be = be;
  endtask

  function automatic logic [15:0] rnd_addr();
    return {4'($urandom), 7'd0, 5'($urandom)};
  endfunction

  initial begin
    logic [3:0] seq;
    n_vec = 0; n_err = 0; cyc = 0; last_dm = 1; last_win = 0;
    reset_n = 0; idle();
    #1;
    repeat (2) tick();
    reset_n = 1;

    // Tie arbitration right after reset: IF, DM, IF, DM.
    if_v = 1; if_addr = 16'h0040; dm_req(0, 16'h0044, 16'h0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      #1; seq[i] = a_if_rdy;
      tick();
    end
    chk("tie_seq", seq, 4'b0101);
    idle(); repeat (3) tick();

    // Preload 0x0010, then a lone IF read returns it one cycle later.
    dm_req(1, 16'h0010, 16'hABCD, 2'b11); tick();
    idle(); if_v = 1; if_addr = 16'h0010;
    #1; chk("t1_ready", a_if_rdy, 1); chk("t1_addr", a_addr, 16'h0010);
    tick(); idle();
    chk("t1_rsp", {a_if_rv, a_if_rd, a_dm_rv}, {1'b1, 16'hABCD, 1'b0});
    repeat (3) tick();

    // Partial store then load of the same address in the next cycle.
    dm_req(1, 16'h0020, 16'h0000, 2'b11); tick();
    dm_req(1, 16'h0020, 16'h1234, 2'b01);
    #1; chk("t3_store", {a_wr, a_be, a_wd}, {1'b1, 2'b01, 16'h1234});
    tick();
    dm_req(0, 16'h0020, 16'h0, 2'b00); tick(); idle();
    chk("t3_lowbyte", {a_dm_rv, a_dm_rd[7:0]}, {1'b1, 8'h34});
    repeat (3) tick();

    // IF read then DM load on consecutive cycles, no cross-delivery.
    dm_req(1, 16'h0100, 16'h1111, 2'b11); tick();
    dm_req(1, 16'h0200, 16'h2222, 2'b11); tick();
    idle(); if_v = 1; if_addr = 16'h0100; tick();
    idle(); dm_req(0, 16'h0200, 16'h0, 2'b00); tick();
    idle(); repeat (4) tick();

    // Reset while a read is in flight drops it; first tie after release goes to IF.
    dm_req(0, 16'h0300, 16'h0, 2'b00); tick();
    idle(); if_v = 1; if_addr = 16'h0010; tick();
    idle(); reset_n = 0; repeat (2) tick();
    reset_n = 1;
    if_v = 1; if_addr = 16'h0050; dm_req(0, 16'h0054, 16'h0, 2'b00);
    #1; chk("t5_tie_if", {a_if_rdy, a_dm_rdy}, 2'b10);
    tick(); idle(); repeat (4) tick();

    // Three back-to-back IF reads (latency-3 instance returns at +3, +4, +5).
    for (int i = 0; i < 3; i++) begin
      if_v = 1; if_addr = 16'h0100 + 16'(i * 2); tick();
    end
    idle(); repeat (6) tick();

    // Randomized traffic with requester hold-until-ready and occasional reset.
    for (int n = 0; n < 3000; n++) begin
      if (!(if_v && last_win != 1) || !reset_n) begin
        if_v = ($urandom_range(0, 99) < 60); if_addr = rnd_addr();
      end
      if (!(dm_v && last_win != 2) || !reset_n) begin
        dm_v = ($urandom_range(0, 99) < 60); dm_wr = 1'($urandom);
        dm_addr = rnd_addr(); dm_wd = 16'($urandom); dm_be = 2'($urandom);
      end
      reset_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset_n = 1; idle(); repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single on-chip memory slave port (16-bit address/data, 2-bit byteenable) between two requesters: instruction fetch (IF) and data memory (DM, loads and stores).
- Sits between the core pipeline and the memory system instance.
- Pipelined: accepts one transfer per cycle, with round-robin grant on conflict.
- Tags every read and returns its data to the owner exactly READ_LATENCY cycles after issue.

Parameters:
- ADDR_W, 16: address width of all address ports.
- DATA_W, 16: data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1: cycles from issue to valid mem_readdata. Legal range 1..3.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req_valid  in  1  IF read request
- if_req_addr  in  ADDR_W  IF read address
- if_req_ready  out  1  IF request accepted this cycle
- if_rsp_valid  out  1  IF read data valid (one-cycle pulse)
- if_rsp_data  out  DATA_W  IF read data
- dm_req_valid  in  1  DM request
- dm_req_write  in  1  1 = store, 0 = load
- dm_req_addr  in  ADDR_W  DM address
- dm_req_wdata  in  DATA_W  store data
- dm_req_be  in  DATA_W/8  store byte enables (ignored for loads)
- dm_req_ready  out  1  DM request accepted this cycle
- dm_rsp_valid  out  1  DM load data valid (one-cycle pulse)
- dm_rsp_data  out  DATA_W  DM load data
- mem_address  out  ADDR_W  to memory s1 address
- mem_clken  out  1  to memory clken
- mem_chipselect  out  1  to memory chipselect
- mem_write  out  1  to memory write
- mem_writedata  out  DATA_W  to memory writedata
- mem_byteenable  out  DATA_W/8  to memory byteenable
- mem_readdata  in  DATA_W  from memory readdata

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Grant is combinational each cycle:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted at the last accepted transfer wins.
  - last_grant resets to DM, so IF wins the first tie after reset.
  - last_grant updates only on an accepted transfer.
- Ready rules:
  - x_req_ready = granted AND x_req_valid.
  - Never both readies high in the same cycle.
  - Transfer (issue) occurs when valid && ready. Requesters hold request fields stable until ready.
- Memory drive during an issue cycle (combinational mux of the granted request):
  - mem_chipselect = 1.
  - mem_address = request address.
  - mem_write = 1 only for a DM store.
  - mem_writedata / mem_byteenable = DM fields on a store.
  - On an IF read or DM load: mem_byteenable = all ones, mem_writedata = 0.
- Idle cycle (no issue): mem_chipselect = 0, mem_write = 0, mem_address = 0, mem_writedata = 0, mem_byteenable = 0.
- mem_clken = 1 whenever reset_n = 1; 0 during reset.
- Response tag pipeline: shift register of depth READ_LATENCY.
  - Each entry holds {vld, owner}. A read issue (IF read or DM load) enters {1, owner}; stores and idle cycles enter {0, x}.
  - Output stage valid with owner IF: if_rsp_valid = 1 for exactly one cycle, if_rsp_data = mem_readdata.
  - Same rule for DM with dm_rsp_valid / dm_rsp_data.
  - Non-owner rsp_valid = 0. rsp_data is 0 whenever its rsp_valid = 0.
- Throughput: one issue per cycle, unlimited back-to-back. Responses return in issue order, one per cycle maximum.
- No backpressure on responses: requesters must accept rsp_valid in the cycle it pulses.
- Stores complete on handshake and generate no response. A load issued the cycle after a store to the same address returns the stored data, because the port is single-ported and ordered.
- Reset:
  - reset_n low at any time immediately clears last_grant (to DM) and all tag entries.
  - In-flight reads are dropped and never produce rsp_valid.
  - All outputs are 0 while reset_n = 0, including both readies and mem_clken.
- Width rules: no address translation or truncation; addresses pass through unchanged.

Test Plan:
- IF only, addr 0x0010, memory returns 0xABCD at latency 1 -> if_req_ready = 1 in the issue cycle, mem_chipselect = 1, mem_address = 0x0010; if_rsp_valid pulses exactly once, 1 cycle later, with if_rsp_data = 0xABCD; dm_rsp_valid stays 0.
- IF and DM loads both held valid for 4 cycles after reset -> grant sequence IF, DM, IF, DM; responses alternate owner in the same order, each at issue +1.
- DM store addr 0x0020, wdata 0x1234, be 2'b01 -> mem_write = 1, mem_byteenable = 01, mem_writedata = 0x1234; no dm_rsp_valid; DM load of 0x0020 in the next cycle returns low byte 0x34.
- IF read 0x0100 then DM load 0x0200 in consecutive cycles, memory data 0x1111 / 0x2222 -> if_rsp 0x1111 then dm_rsp 0x2222 on consecutive cycles, no cross-delivery.
- IF read issued, reset_n pulled low the next cycle before the response -> no if_rsp_valid ever appears; all outputs 0 during reset; first tie after release grants IF.
- READ_LATENCY = 3, three back-to-back IF reads -> three if_rsp_valid pulses on cycles issue+3, +4, +5 carrying the matching mem_readdata values.
